// File: rtl/split_sync.sv
// rtl/split_sync.sv - synchronous 1-to-2 split: joins a data token with a select token, routes to one of two FIFOs
module split_sync #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] In_data,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic             S_data,
  input  logic             S_valid,
  output logic             S_ready,
  output logic [WIDTH-1:0] Out0_data,
  output logic             Out0_valid,
  input  logic             Out0_ready,
  output logic [WIDTH-1:0] Out1_data,
  output logic             Out1_valid,
  input  logic             Out1_ready,
  output logic [CNT_W-1:0] Out0_count,
  output logic [CNT_W-1:0] Out1_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem  [2][DEPTH];
  logic [PW-1:0]    wptr [2];
  logic [PW-1:0]    rptr [2];
  logic [OW-1:0]    occ  [2];
  logic [CNT_W-1:0] cnt  [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready;
  logic             full_s;
  logic             fire;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_ready = {Out1_ready, Out0_ready};
  assign full[0]   = (occ[0] == OW'(DEPTH));
  assign full[1]   = (occ[1] == OW'(DEPTH));
  assign full_s    = S_data ? full[1] : full[0];
  // Readies depend only on registered occupancy, never on downstream ready.
  assign fire      = In_valid & S_valid & ~full_s & ~RESET;
  assign In_ready  = fire;
  assign S_ready   = fire;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 2; k++) begin
      push[k] = fire & (S_data == 1'(k));
      pop[k]  = (occ[k] != '0) & out_ready[k];
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wptr[k]] <= In_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        occ[k]  <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wptr[k] <= nxt(wptr[k]);
        if (pop[k]) begin
          rptr[k] <= nxt(rptr[k]);
          cnt[k]  <= cnt[k] + 1'b1;
        end
        occ[k] <= occ[k] + OW'(push[k]) - OW'(pop[k]);
      end
    end
  end

  assign Out0_valid = (occ[0] != '0);
  assign Out1_valid = (occ[1] != '0);
  assign Out0_data  = Out0_valid ? mem[0][rptr[0]] : '0;
  assign Out1_data  = Out1_valid ? mem[1][rptr[1]] : '0;
  assign Out0_count = cnt[0];
  assign Out1_count = cnt[1];

endmodule
